usi_master: RTL
===============

USI_MASTER -- requirements
Module: usi_master

Interface
REQ-001 SHALL have parameter pBusAdrsBit, default 32, the USI address width.
REQ-002 SHALL have parameter pTimeout, default 16, the maximum number of RD_WAIT cycles before a read aborts (1 to 255).
REQ-003 SHALL have one clock and a synchronous, active-high reset, with these ports:
  iSysClk  in  1  system clock; all logic on rising edge
  iSysRst  in  1  synchronous active-high reset
  iCmdValid  in  1  command request
  oCmdReady  out  1  command accepted when high with iCmdValid
  iCmdWrite  in  1  1 = write, 0 = read
  iCmdAdrs  in  pBusAdrsBit  command address
  iCmdWd  in  32  write data
  oRspValid  out  1  one-cycle response pulse
  oRspRd  out  32  read data (0 for writes and timeouts)
  oRspTimeout  out  1  read aborted; qualified by oRspValid
  oMUsiWd  out  32  bus write data
  oMUsiAdrs  out  pBusAdrsBit  bus address
  oMUsiWCke  out  1  bus write enable
  iMUsiRd  in  32  OR-combined slave read data
  iMUsiREd  in  1  OR-combined slave read-valid
  oBusy  out  1  high in every state except IDLE

Function
REQ-004 SHALL implement the states IDLE, WR, RD_ADRS, RD_WAIT and RESP.
REQ-005 SHALL drive oCmdReady=1 only in IDLE; a handshake is iCmdValid&oCmdReady at a rising edge; iCmdValid outside IDLE SHALL be ignored.
REQ-006 SHALL, on a handshake, latch iCmdAdrs/iCmdWd/iCmdWrite and move to WR (write) or RD_ADRS (read).
REQ-007 SHALL, in WR, drive oMUsiWCke=1 and oMUsiWd=latched data for exactly one cycle, then go to RESP.
REQ-008 SHALL drive oMUsiWCke=0 and oMUsiWd=0 in every state except WR.
REQ-009 SHALL drive oMUsiAdrs=latched address from the cycle after the handshake, and hold it after the command completes until the next handshake.
REQ-010 SHALL spend one cycle in RD_ADRS with iMUsiREd ignored, because a slave's registered REd may still reflect the previous address, then go to RD_WAIT.
REQ-011 SHALL, in RD_WAIT, capture iMUsiRd into oRspRd and go to RESP with timeout=0 in the first cycle iMUsiREd=1.
REQ-012 SHALL count RD_WAIT cycles; if pTimeout cycles elapse without REd, go to RESP with oRspRd=0 and timeout=1.
REQ-013 SHALL, when REd arrives in the same cycle the count reaches pTimeout, treat the read as a success (REd wins).
REQ-014 SHALL ignore iMUsiREd in IDLE, WR, RD_ADRS and RESP; slaves assert REd on any address match, including during writes.
REQ-015 SHALL assert oRspValid=1 for exactly one cycle in RESP, then return to IDLE; oRspRd and oRspTimeout hold their value until the next RESP.
REQ-016 SHALL make a write response carry oRspRd=0 and oRspTimeout=0.
REQ-017 SHALL have latency with a zero-wait slave of: write handshake at cycle 0 -> WCke at cycle 1 -> oRspValid at cycle 2; read handshake at cycle 0 -> RD_ADRS at cycle 1 -> REd seen at cycle 2 -> oRspValid at cycle 3.
REQ-018 SHALL accept a new command no earlier than the IDLE cycle following RESP; maximum throughput is one write per 3 cycles.

Reset
REQ-019 SHALL, while iSysRst=1, go to IDLE and hold oCmdReady=0, oRspValid=0, oRspRd=0, oRspTimeout=0, oMUsiWd=0, oMUsiAdrs=0, oMUsiWCke=0 and oBusy=0.
REQ-020 SHALL, on reset mid-command (any state), abandon the command with no response pulse and no WCke; oCmdReady=1 in the first cycle after reset deasserts.

Verification
REQ-021 SHALL pass: write adrs 0x0004_0004, data 0x0000_00FF -> one cycle WCke=1 with that adrs/data, oRspValid at +2, oRspRd=0, timeout=0.
REQ-022 SHALL pass: read 0x0004_0080, slave returns REd+0x0000_1234 one cycle after the address -> oRspRd=0x0000_1234, oRspValid at +3.
REQ-023 SHALL pass: REd held high from a previous same-block read, new read to 0x0004_0084 -> REd ignored in RD_ADRS; the new data (0x1) is captured from RD_WAIT.
REQ-024 SHALL pass: read with no slave response, pTimeout=16 -> oRspValid after 16 RD_WAIT cycles, oRspTimeout=1, oRspRd=0.
REQ-025 SHALL pass: REd on exactly the 16th RD_WAIT cycle -> success with captured data, timeout=0.
REQ-026 SHALL pass: reset asserted in RD_WAIT, and separately iCmdValid held high during WR -> no response pulse after reset; the held iCmdValid command is accepted only after RESP->IDLE.

Source files
------------

// File: rtl/usi_master_if.sv
// ---------------------------------------------------------------------------
// usi_master_if
// Bundles the command/response handshake and the USI bus signals that
// usi_master drives and observes.
//   master modport : view used by usi_master itself
//   slave  modport : view used by whatever drives commands and the bus slaves
// Command side : iCmdValid/oCmdReady handshake, iCmdWrite, iCmdAdrs, iCmdWd
// Response side: oRspValid pulse, oRspRd, oRspTimeout, oBusy
// Bus side     : oMUsiAdrs, oMUsiWd, oMUsiWCke out; iMUsiRd, iMUsiREd in
// ---------------------------------------------------------------------------
interface usi_master_if #(
  parameter int pBusAdrsBit = 32
);
  logic                   iCmdValid;
  logic                   oCmdReady;
  logic                   iCmdWrite;
  logic [pBusAdrsBit-1:0] iCmdAdrs;
  logic [31:0]            iCmdWd;
  logic                   oRspValid;
  logic [31:0]            oRspRd;
  logic                   oRspTimeout;
  logic [31:0]            oMUsiWd;
  logic [pBusAdrsBit-1:0] oMUsiAdrs;
  logic                   oMUsiWCke;
  logic [31:0]            iMUsiRd;
  logic                   iMUsiREd;
  logic                   oBusy;

  modport master (
    input  iCmdValid, iCmdWrite, iCmdAdrs, iCmdWd, iMUsiRd, iMUsiREd,
    output oCmdReady, oRspValid, oRspRd, oRspTimeout,
           oMUsiWd, oMUsiAdrs, oMUsiWCke, oBusy
  );

  modport slave (
    output iCmdValid, iCmdWrite, iCmdAdrs, iCmdWd, iMUsiRd, iMUsiREd,
    input  oCmdReady, oRspValid, oRspRd, oRspTimeout,
           oMUsiWd, oMUsiAdrs, oMUsiWCke, oBusy
  );
endinterface

// File: rtl/usi_master.sv
// ---------------------------------------------------------------------------
// usi_master
// Single-outstanding USI bus master. Accepts one command at a time, performs
// a one-cycle write strobe or an address/wait read with a bounded timeout,
// and reports completion with a one-cycle response pulse.
// Ports:
//   iSysClk : system clock, rising edge
//   iSysRst : synchronous active-high reset
//   ifc     : usi_master_if.master (command, response and bus signals)
// Parameters:
//   pBusAdrsBit : bus address width
//   pTimeout    : RD_WAIT cycles allowed before a read aborts (1..255)
// ---------------------------------------------------------------------------
module usi_master #(
  parameter int pBusAdrsBit = 32,
  parameter int pTimeout    = 16
) (
  input  logic           iSysClk,
  input  logic           iSysRst,
  usi_master_if.master   ifc
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] RD_ADRS = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  localparam logic [7:0] TIMEOUT_CNT = 8'(pTimeout);

  logic [2:0]             r_state;
  logic [pBusAdrsBit-1:0] r_adrs;
  logic [31:0]            r_wd;
  logic [31:0]            r_rsp_rd;
  logic                   r_rsp_to;
  logic [7:0]             r_cnt;

  // Outputs are forced to their idle values for as long as reset is held,
  // not only after the first reset edge.
  logic w_run;
  logic w_wcke;

  assign w_run  = ~iSysRst;
  assign w_wcke = w_run && (r_state == WR);

  assign ifc.oCmdReady   = w_run && (r_state == IDLE);
  assign ifc.oBusy       = w_run && (r_state != IDLE);
  assign ifc.oRspValid   = w_run && (r_state == RESP);
  assign ifc.oRspRd      = w_run ? r_rsp_rd : 32'd0;
  assign ifc.oRspTimeout = w_run && r_rsp_to;
  assign ifc.oMUsiWCke   = w_wcke;
  assign ifc.oMUsiWd     = w_wcke ? r_wd : 32'd0;
  assign ifc.oMUsiAdrs   = w_run ? r_adrs : '0;

  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      r_state  <= IDLE;
      r_adrs   <= '0;
      r_wd     <= '0;
      r_rsp_rd <= '0;
      r_rsp_to <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ifc.iCmdValid) begin
            r_adrs  <= ifc.iCmdAdrs;
            r_wd    <= ifc.iCmdWd;
            r_state <= ifc.iCmdWrite ? WR : RD_ADRS;
          end
        end
        WR: begin
          r_rsp_rd <= '0;
          r_rsp_to <= 1'b0;
          r_state  <= RESP;
        end
        // REd is not trusted here: a registered slave may still be answering
        // the previous address. r_cnt counts RD_WAIT cycles starting at 1.
        RD_ADRS: begin
          r_cnt   <= 8'd1;
          r_state <= RD_WAIT;
        end
        // REd is checked before the count so a reply on the last allowed
        // cycle still succeeds.
        RD_WAIT: begin
          if (ifc.iMUsiREd) begin
            r_rsp_rd <= ifc.iMUsiRd;
            r_rsp_to <= 1'b0;
            r_state  <= RESP;
          end else if (r_cnt >= TIMEOUT_CNT) begin
            r_rsp_rd <= '0;
            r_rsp_to <= 1'b1;
            r_state  <= RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
